prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Write-side counterpart of the instruction fetch path. The CPU only reads instruction memory; this block fills it.
- Accepts a byte stream from a host link (valid/ready), assembles big-endian 32-bit instruction words and drives the instruction memory write port at word addresses BASE, BASE+1, …, matching the PC's +1 per instruction stepping.
- Holds the CPU (Cpu_Hold) while a program is being loaded and releases it when loading finishes.

Parameters:
- DEPTH, 256, instruction memory capacity in words; maximum legal program length.
- ADDR_W, 32, width of Wr_Addr (matches PC width).
- BASE, 0, word address of the first loaded instruction.

Ports:
- Clk  input  1  system clock; all logic on the rising edge.
- Rst  input  1  synchronous, active-low reset.
- Start  input  1  one-cycle request to begin a load.
- In_Data  input  8  host byte.
- In_Valid  input  1  In_Data is valid.
- In_Ready  output  1  loader accepts a byte this cycle.
- Wr_En  output  1  instruction memory write strobe, one cycle per word.
- Wr_Addr  output  ADDR_W  instruction memory word address.
- Wr_Data  output  32  instruction word.
- Cpu_Hold  output  1  keeps the PC/CPU in reset while high.
- Done  output  1  one-cycle pulse when a load completes successfully.
- Error  output  1  sticky; set on an illegal program length.

Behaviour:
- Reset (Rst=0 at a clock edge):
  - State goes to IDLE.
  - All outputs are 0: In_Ready, Wr_En, Wr_Addr, Wr_Data, Cpu_Hold, Done, Error.
  - Counters are cleared.
  - Memory contents are untouched. Reset in the middle of a load leaves a partial image and Cpu_Hold=0.
- Handshake:
  - A byte is accepted only when In_Valid=1 and In_Ready=1 on the same edge.
  - In_Ready=1 exactly in states LEN and DATA. There is no backpressure inside those states.
  - In_Data is ignored when it is not accepted.
- States:
  - IDLE: Start=1 moves to LEN and sets Cpu_Hold=1 from the next cycle.
  - LEN:
    - Collects 4 bytes, MSB first, into a 32-bit word count N.
    - On the edge accepting the 4th byte, goes to DATA if 1 ≤ N ≤ DEPTH.
    - Otherwise goes to ERR with Error=1 the next cycle.
  - DATA:
    - Collects 4 bytes per word, MSB first.
    - On the edge accepting the 4th byte of word i (0-based), the next cycle has Wr_En=1, Wr_Addr=BASE+i, Wr_Data=assembled word.
    - Wr_En is a single-cycle pulse. Wr_Addr and Wr_Data hold their last values when Wr_En=0.
    - A new byte may be accepted in the same cycle as the Wr_En pulse (back-to-back words allowed).
    - After the 4th byte of word N-1 is accepted, goes to DONE.
  - DONE (one cycle):
    - Done=1 and Cpu_Hold=0 in this cycle; the final Wr_En pulse is also this cycle.
    - Next state is IDLE.
  - ERR:
    - Error=1 and Cpu_Hold=1 (the CPU must not run an invalid image). In_Ready=0.
    - Start=1 clears Error and goes to LEN.
- Start is ignored in LEN, DATA and DONE.
- Word index counter width is clog2(DEPTH)+1; it never wraps, because N ≤ DEPTH is enforced.
- Byte-lane counter (2 bits) resets to 0 at entry to LEN and at each word boundary.

Test Plan:
- Rst=0 for 2 cycles, then Rst=1 -> all outputs 0, state IDLE, In_Ready=0.
- Start, then bytes 00 00 00 02, 12 34 56 78, 9A BC DE F0 with In_Valid held high -> Wr_En pulses with (addr 0, 0x12345678) and (addr 1, 0x9ABCDEF0); Done=1 in the cycle of the second write; Cpu_Hold high from the cycle after Start until Done, then 0.
- Same program with In_Valid toggling 1/0 every cycle -> identical writes and data; only timing stretches; no byte lost or duplicated.
- DEPTH=256 and length bytes 00 00 01 01 (N=257) -> Error=1, Cpu_Hold stays 1, In_Ready=0, no Wr_En. Then Start with a valid N=1 -> Error clears and the load completes.
- N=0 -> Error=1 and no writes. Start pulsed during DATA -> ignored; the load continues unaffected.
- Rst=0 after 2 of 3 words written -> all outputs 0 on the next cycle; a fresh Start reloads from address BASE.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: fills instruction memory from a host byte stream.
//   A load is a 4-byte big-endian word count N followed by N big-endian
//   32-bit instruction words. Word i is written at address BASE+i.
//   The CPU is held while a load is running, and it stays held after an
//   illegal length.
// Ports:
//   Clk, Rst        clock; synchronous active-low reset
//   Start           one-cycle load request (honoured in IDLE and ERR)
//   In_Data/Valid   host byte stream; In_Ready is high in LEN and DATA
//   Wr_En/Addr/Data instruction memory write port (one-cycle strobe)
//   Cpu_Hold        keeps the CPU in reset while high
//   Done            one-cycle pulse when a load completes
//   Error           sticky illegal-length flag, cleared by Start
module prog_loader #(
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned BASE   = 0
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic [7:0]        In_Data,
    input  logic              In_Valid,
    output logic              In_Ready,
    output logic              Wr_En,
    output logic [ADDR_W-1:0] Wr_Addr,
    output logic [31:0]       Wr_Data,
    output logic              Cpu_Hold,
    output logic              Done,
    output logic              Error
);

    localparam int unsigned IDX_W = $clog2(DEPTH) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_DONE,
        S_ERR
    } state_t;

    state_t              state_q,    state_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [23:0]         shift_q,    shift_d;
    logic [IDX_W-1:0]    word_idx_q, word_idx_d;
    logic [IDX_W-1:0]    len_q,      len_d;
    logic                in_ready_q, in_ready_d;
    logic                wr_en_q,    wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q,  wr_addr_d;
    logic [31:0]         wr_data_q,  wr_data_d;
    logic                cpu_hold_q, cpu_hold_d;
    logic                done_q,     done_d;
    logic                error_q,    error_d;

    logic                accept;
    logic [31:0]         word;
    logic                len_ok;

    always_comb begin
        accept = In_Valid && in_ready_q;
        // The first three bytes of a word sit in shift_q; the fourth arrives live.
        word   = {shift_q, In_Data};
        len_ok = (word != '0) && (word <= 32'(DEPTH));

        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        word_idx_d = word_idx_q;
        len_d      = len_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        case (state_q)
            S_IDLE, S_ERR: begin
                if (Start) begin
                    state_d    = S_LEN;
                    byte_cnt_d = '0;
                end
            end
            S_LEN: begin
                if (accept) begin
                    shift_d    = word[23:0];
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (len_ok) begin
                            state_d    = S_DATA;
                            len_d      = word[IDX_W-1:0];
                            word_idx_d = '0;
                        end else begin
                            state_d = S_ERR;
                        end
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    shift_d    = word[23:0];
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        wr_en_d    = 1'b1;
                        wr_addr_d  = ADDR_W'(BASE) + ADDR_W'(word_idx_q);
                        wr_data_d  = word;
                        word_idx_d = word_idx_q + IDX_W'(1);
                        if (word_idx_q == len_q - IDX_W'(1)) begin
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status outputs are registered copies of the next state's decode,
        // so each appears in the same cycle as the state it belongs to.
        in_ready_d = (state_d == S_LEN) || (state_d == S_DATA);
        cpu_hold_d = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_ERR);
        done_d     = (state_d == S_DONE);
        error_d    = (state_d == S_ERR);
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            word_idx_q <= '0;
            len_q      <= '0;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            cpu_hold_q <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            word_idx_q <= word_idx_d;
            len_q      <= len_d;
            in_ready_q <= in_ready_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign In_Ready = in_ready_q;
    assign Wr_En    = wr_en_q;
    assign Wr_Addr  = wr_addr_q;
    assign Wr_Data  = wr_data_q;
    assign Cpu_Hold = cpu_hold_q;
    assign Done     = done_q;
    assign Error    = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized self-checking bench for prog_loader.
//   Programs are built as lists of words, serialized to bytes and streamed
//   in; the expected write list is the word list itself at BASE+i.
module tb_prog_loader;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned BASE  = 0;

    typedef logic [31:0] word_q_t[$];
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        Start = 1'b0;
    logic [7:0]  In_Data = '0;
    logic        In_Valid = 1'b0;
    logic        In_Ready;
    logic        Wr_En;
    logic [31:0] Wr_Addr;
    logic [31:0] Wr_Data;
    logic        Cpu_Hold;
    logic        Done;
    logic        Error;

    int pass_cnt = 0;
    int total_cnt = 0;
    wr_t got[$];

    prog_loader #(.DEPTH(DEPTH), .ADDR_W(32), .BASE(BASE)) dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .In_Data(In_Data),
        .In_Valid(In_Valid), .In_Ready(In_Ready), .Wr_En(Wr_En),
        .Wr_Addr(Wr_Addr), .Wr_Data(Wr_Data), .Cpu_Hold(Cpu_Hold),
        .Done(Done), .Error(Error)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (Wr_En === 1'b1) got.push_back('{Wr_Addr, Wr_Data});
    end

    // gap_mode: 0 = valid held, 1 = valid toggles every cycle, 2 = random gaps
    task automatic send_byte(input logic [7:0] b, input int gap_mode, input bit with_start);
        int k;
        if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 1) == 1)) begin
            In_Valid = 1'b0;
            In_Data  = 8'($urandom);
            @(negedge Clk);
        end
        In_Data  = b;
        In_Valid = 1'b1;
        Start    = with_start;
        k = 0;
        while (In_Ready !== 1'b1 && k < 50) begin
            @(negedge Clk);
            Start = 1'b0;
            k++;
        end
        if (In_Ready !== 1'b1) begin
            total_cnt++;
            $display("FAIL byte_accept: In_Ready stuck at %b, required 1 within 50 cycles", In_Ready);
        end
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic run_load(input logic [31:0] n_field, input word_q_t words,
                            input int gap_mode, input int start_mid, input bit expect_ok);
        wr_t exp[$];
        int idx;
        got.delete();
        foreach (words[i]) exp.push_back('{BASE + 32'(i), words[i]});

        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        total_cnt++; if (Cpu_Hold !== 1'b1) $display("FAIL hold_after_start: got %b want 1", Cpu_Hold); else pass_cnt++;
        total_cnt++; if (In_Ready !== 1'b1) $display("FAIL ready_in_len: got %b want 1", In_Ready); else pass_cnt++;
        total_cnt++; if (Error !== 1'b0) $display("FAIL error_cleared: got %b want 0", Error); else pass_cnt++;

        idx = 0;
        for (int j = 3; j >= 0; j--) begin
            send_byte(n_field[j*8 +: 8], gap_mode, idx == start_mid);
            idx++;
        end
        foreach (words[w]) begin
            for (int j = 3; j >= 0; j--) begin
                send_byte(words[w][j*8 +: 8], gap_mode, idx == start_mid);
                idx++;
            end
        end
        In_Valid = 1'b0;

        if (expect_ok) begin
            total_cnt++; if (Done !== 1'b1) $display("FAIL done_pulse: got %b want 1", Done); else pass_cnt++;
            total_cnt++; if (Wr_En !== 1'b1) $display("FAIL last_write_with_done: got %b want 1", Wr_En); else pass_cnt++;
            total_cnt++; if (Cpu_Hold !== 1'b0) $display("FAIL hold_released: got %b want 0", Cpu_Hold); else pass_cnt++;
            @(negedge Clk);
            total_cnt++; if (Done !== 1'b0) $display("FAIL done_one_cycle: got %b want 0", Done); else pass_cnt++;
            total_cnt++; if (Wr_En !== 1'b0) $display("FAIL wr_en_one_cycle: got %b want 0", Wr_En); else pass_cnt++;
            total_cnt++; if (In_Ready !== 1'b0) $display("FAIL ready_idle: got %b want 0", In_Ready); else pass_cnt++;
            total_cnt++;
            if (got.size() != exp.size()) $display("FAIL write_count: got %0d want %0d", got.size(), exp.size());
            else pass_cnt++;
            foreach (exp[i]) begin
                if (i < got.size()) begin
                    total_cnt++;
                    if (got[i].addr !== exp[i].addr || got[i].data !== exp[i].data)
                        $display("FAIL write[%0d]: got addr %0d data %h want addr %0d data %h",
                                 i, got[i].addr, got[i].data, exp[i].addr, exp[i].data);
                    else pass_cnt++;
                end
            end
        end else begin
            total_cnt++; if (Error !== 1'b1) $display("FAIL error_set: got %b want 1", Error); else pass_cnt++;
            total_cnt++; if (Cpu_Hold !== 1'b1) $display("FAIL hold_in_err: got %b want 1", Cpu_Hold); else pass_cnt++;
            total_cnt++; if (In_Ready !== 1'b0) $display("FAIL ready_in_err: got %b want 0", In_Ready); else pass_cnt++;
            In_Valid = 1'b1;
            In_Data  = 8'hA5;
            repeat (3) @(negedge Clk);
            In_Valid = 1'b0;
            total_cnt++; if (Error !== 1'b1) $display("FAIL error_sticky: got %b want 1", Error); else pass_cnt++;
            total_cnt++; if (Cpu_Hold !== 1'b1) $display("FAIL hold_sticky: got %b want 1", Cpu_Hold); else pass_cnt++;
            total_cnt++; if (got.size() != 0) $display("FAIL no_write_on_err: got %0d writes want 0", got.size()); else pass_cnt++;
        end
    endtask

    task automatic test_reset();
        Rst = 1'b0;
        repeat (2) @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        total_cnt++;
        if ({In_Ready, Wr_En, Wr_Addr, Wr_Data, Cpu_Hold, Done, Error} !== '0)
            $display("FAIL reset_outputs: got rdy%b we%b a%h d%h h%b dn%b e%b want all 0",
                     In_Ready, Wr_En, Wr_Addr, Wr_Data, Cpu_Hold, Done, Error);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        word_q_t w = '{32'h12345678, 32'h9ABCDEF0};
        run_load(32'd2, w, 0, -1, 1'b1);
    endtask

    task automatic test_toggle_valid();
        word_q_t w = '{32'h12345678, 32'h9ABCDEF0};
        run_load(32'd2, w, 1, -1, 1'b1);
    endtask

    task automatic test_random();
        for (int t = 0; t < 4; t++) begin
            word_q_t w;
            int n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) w.push_back($urandom);
            run_load(32'(n), w, 2, -1, 1'b1);
        end
    endtask

    task automatic test_len_too_big();
        word_q_t none;
        word_q_t w;
        run_load(32'd257, none, 0, -1, 1'b0);
        w.push_back($urandom);
        run_load(32'd1, w, 0, -1, 1'b1);
    endtask

    task automatic test_len_zero_and_start_mid();
        word_q_t none;
        word_q_t w;
        run_load(32'd0, none, 0, -1, 1'b0);
        for (int i = 0; i < 3; i++) w.push_back($urandom);
        run_load(32'd3, w, 2, 6, 1'b1);
    endtask

    task automatic test_full_depth();
        word_q_t w;
        for (int i = 0; i < int'(DEPTH); i++) w.push_back($urandom);
        run_load(32'(DEPTH), w, 0, -1, 1'b1);
    endtask

    task automatic test_reset_mid_load();
        word_q_t w;
        logic [31:0] n = 32'd3;
        for (int i = 0; i < 3; i++) w.push_back($urandom);
        got.delete();
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        for (int j = 3; j >= 0; j--) send_byte(n[j*8 +: 8], 0, 1'b0);
        for (int k = 0; k < 2; k++)
            for (int j = 3; j >= 0; j--) send_byte(w[k][j*8 +: 8], 0, 1'b0);
        In_Valid = 1'b0;
        Rst = 1'b0;
        @(negedge Clk);
        total_cnt++;
        if ({In_Ready, Wr_En, Wr_Addr, Wr_Data, Cpu_Hold, Done, Error} !== '0)
            $display("FAIL midload_reset_outputs: got rdy%b we%b a%h d%h h%b dn%b e%b want all 0",
                     In_Ready, Wr_En, Wr_Addr, Wr_Data, Cpu_Hold, Done, Error);
        else pass_cnt++;
        total_cnt++;
        if (got.size() != 2) $display("FAIL midload_writes: got %0d want 2", got.size()); else pass_cnt++;
        Rst = 1'b1;
        @(negedge Clk);
        run_load(32'd3, w, 0, -1, 1'b1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_toggle_valid();
        test_random();
        test_len_too_big();
        test_len_zero_and_start_mid();
        test_full_depth();
        test_reset_mid_load();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
